uart_frame_seq: RTL

//  Upstream feeder for the UART transmitter. On a one-cycle send request it latches a fixed-size

---
 rtl/uart_frame_seq_if.sv | 31 +++
 rtl/uart_frame_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_frame_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_frame_seq_if                                             |
// | Brief    : Bundle of request/payload and transmitter handshake signals   |
// |            between a frame producer and the UART transmitter feeder.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface uart_frame_seq_if #(
  parameter int PAYLOAD_BYTES = 6
);
  logic                         send;
  logic [8*PAYLOAD_BYTES-1:0]   payload;
  logic                         tx_done;
  logic                         trmt;
  logic [7:0]                   tx_data;
  logic                         busy;
  logic                         frame_done;

  // Requester / transmitter environment side
  modport master (
    output send, payload, tx_done,
    input  trmt, tx_data, busy, frame_done
  );

  // Frame sequencer side
  modport slave (
    input  send, payload, tx_done,
    output trmt, tx_data, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_frame_seq                                                |
// | Brief    : Streams HEADER, LEN, payload bytes and an inverted additive   |
// |            checksum into a UART transmitter, one byte per trmt pulse,    |
// |            pacing itself on the transmitter's tx_done level.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_frame_seq #(
  parameter int          PAYLOAD_BYTES = 6,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  uart_frame_seq_if.slave     bus
);

  localparam logic [7:0] c_len_byte = 8'(PAYLOAD_BYTES);
  localparam logic [4:0] c_last_idx = 5'(PAYLOAD_BYTES + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CLR  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                       state_q,      state_d;
  logic [8*PAYLOAD_BYTES-1:0]   payload_q,    payload_d;
  logic [4:0]                   idx_q,        idx_d;
  logic [7:0]                   chk_q,        chk_d;
  logic                         trmt_q,       trmt_d;
  logic [7:0]                   tx_data_q,    tx_data_d;
  logic                         busy_q,       busy_d;
  logic                         frame_done_q, frame_done_d;
  logic [7:0]                   sel_byte;

  // Pick the byte belonging to the current frame position; the checksum slot
  // uses the running sum, which by then holds LEN plus every payload byte.
  always_comb begin
    sel_byte = 8'h00;
    if (idx_q == 5'd0) begin
      sel_byte = HEADER;
    end else if (idx_q == 5'd1) begin
      sel_byte = c_len_byte;
    end else if (idx_q == c_last_idx) begin
      sel_byte = ~chk_q;
    end else begin
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        if (idx_q == 5'(k + 2)) begin
          sel_byte = payload_q[8*k +: 8];
        end
      end
    end
  end

  // Next-state and registered-output computation for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    trmt_d       = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          payload_d = bus.payload;
          idx_d     = 5'd0;
          chk_d     = 8'h00;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        trmt_d    = 1'b1;
        tx_data_d = sel_byte;
        // HEADER and the checksum itself do not contribute to the sum
        if ((idx_q != 5'd0) && (idx_q != c_last_idx)) begin
          chk_d = chk_q + sel_byte;
        end
        state_d = S_CLR;
      end
      S_CLR: begin
        // The transmitter still shows the previous tx_done here
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          if (idx_q == c_last_idx) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      payload_q    <= '0;
      idx_q        <= 5'd0;
      chk_q        <= 8'h00;
      trmt_q       <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      payload_q    <= payload_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      trmt_q       <= trmt_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
